alu_dual_mode: RTL and testbench
================================

Name: alu_dual_mode

Overview:
- Registered 8-bit two-operand ALU with two instruction sets: mode A (logic) and mode B (arithmetic/shift), selected by per-mode enables.
- Produces a registered result and a sticky interrupt flag for defined result events; software clears the flag via alu_irq_clr.
- Sits behind the ALU bus interface (ifc) and is driven one operation per clock.

Parameters:
- DATA_W, 8, operand/result width. All values in this spec assume 8.

Ports:
- alu_clk  in  1  clock; all state updates on the rising edge.
- alu_rst_n  in  1  synchronous, active-low reset, sampled on the alu_clk rising edge.
- alu_enable  in  1  global enable; no operation executes when low.
- alu_enable_a  in  1  selects mode A.
- alu_enable_b  in  1  selects mode B.
- alu_op_a  in  2  mode A opcode.
- alu_op_b  in  2  mode B opcode.
- alu_in_a  in  DATA_W  operand A.
- alu_in_b  in  DATA_W  operand B.
- alu_irq_clr  in  1  clears alu_irq.
- alu_out  out  DATA_W  registered result.
- alu_irq  out  1  sticky interrupt flag.

Behaviour:
- Reset (alu_rst_n=0 at an edge): alu_out=0x00, alu_irq=0. Reset overrides every other input. Reset during operation discards the pending result.
- Valid op:
  - Executes when alu_enable=1 and exactly one of alu_enable_a/alu_enable_b is 1.
  - Result is registered at that edge, so latency is 1 cycle. Back-to-back ops run every cycle.
- Hold: when alu_enable=0, or both mode enables are 0, alu_out holds its value and no irq event occurs.
- Illegal (alu_enable=1, alu_enable_a=1, alu_enable_b=1): alu_out holds. alu_irq behaviour depends on ALU_ILLEGAL_IRQ_EN.
- Mode A opcodes:
  - 00: a AND b
  - 01: NOT(a AND b)
  - 10: a OR b
  - 11: a XOR b
- Mode B opcodes:
  - 00: a+b, modulo 256; carry out = bit 8 of the sum.
  - 01: a−b, modulo 256; borrow when a<b.
  - 10: a shifted left by b[2:0], zero fill.
  - 11: a shifted right (logical) by b[2:0], zero fill.
- Irq events, evaluated on the newly computed result of a valid op:
  - Mode A: result == 0xFF.
  - Mode B: ADD carry out, SUB borrow, or result == 0x00 for any mode B op.
- Irq rules:
  - An event sets alu_irq at the same edge alu_out updates.
  - alu_irq stays 1 until an edge with alu_irq_clr=1 and no new event.
  - Event and clear at the same edge: the event wins, so alu_irq=1.
  - Clear with no event: alu_irq=0 next cycle.
  - Clear has no effect on alu_out.
- Opcode inputs of the unselected mode are ignored.

Optional Feature:
- Macro: ALU_ILLEGAL_IRQ_EN.
- Defined: an illegal enable combination sets alu_irq, using the same sticky/clear rules as other events; alu_out still holds.
- Undefined: an illegal combination is a silent hold with no irq change.

Decomposition:
- Package alu_pkg holds:
  - DATA_W
  - enum op_a_e {OPA_AND, OPA_NAND, OPA_OR, OPA_XOR}
  - enum op_b_e {OPB_ADD, OPB_SUB, OPB_SHL, OPB_SHR}
  - constant IRQ_A_VAL = 8'hFF
- One sub-module, alu_irq_ctrl: the sticky flag with set-priority clear. It takes event, illegal and clear inputs and produces alu_irq.
- Datapath and mode decode stay in the top module.

Test Plan:
- Reset: hold alu_rst_n=0 for 2 edges while driving a valid op → alu_out=0x00 and alu_irq=0. Release, then mode A XOR with a=0x0F, b=0xF0 → alu_out=0xFF one cycle later and alu_irq=1.
- Mode A sweep, a=0xCC, b=0xAA, ops 00..11 → 0x88, 0x77, 0xEE, 0x66 on consecutive cycles; no irq.
- Mode B arithmetic, each from a cleared irq:
  - ADD 0x80+0x80 → 0x00, irq=1.
  - ADD 0x12+0x34 → 0x46, irq=0.
  - SUB 0x05−0x07 → 0xFE, irq=1 (borrow).
  - SHL 0x81 by 1 → 0x02.
  - SHR 0x81 by 3 → 0x10.
- Irq clear race:
  - With irq=1, pulse alu_irq_clr alongside ADD 0xFF+0x01 → irq stays 1.
  - Next cycle, clr=1 with mode A AND 0x0F&0x0F → irq=0, alu_out=0x0F.
- Hold and illegal:
  - alu_enable=0 with operands changing → alu_out unchanged.
  - Both mode enables=1 → alu_out unchanged; alu_irq=1 only if ALU_ILLEGAL_IRQ_EN is defined, else unchanged.
- Mid-operation reset: alu_out=0x46 and irq=1, assert alu_rst_n=0 for 1 edge alongside a valid op → alu_out=0x00 and irq=0 at that edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared width, opcode encodings and irq constant for the dual-mode ALU.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OPA_AND  = 2'b00,
    OPA_NAND = 2'b01,
    OPA_OR   = 2'b10,
    OPA_XOR  = 2'b11
  } op_a_e;

  typedef enum logic [1:0] {
    OPB_ADD = 2'b00,
    OPB_SUB = 2'b01,
    OPB_SHL = 2'b10,
    OPB_SHR = 2'b11
  } op_b_e;

  localparam logic [DATA_W-1:0] IRQ_A_VAL = 8'hFF;

endpackage

// File: rtl/alu_if.sv
// ALU bus: operation request and operands from the master, result and irq from the ALU.
interface alu_if;
  import alu_pkg::*;

  logic              alu_enable;
  logic              alu_enable_a;
  logic              alu_enable_b;
  logic [1:0]        alu_op_a;
  logic [1:0]        alu_op_b;
  logic [DATA_W-1:0] alu_in_a;
  logic [DATA_W-1:0] alu_in_b;
  logic              alu_irq_clr;
  logic [DATA_W-1:0] alu_out;
  logic              alu_irq;

  modport master (
    output alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b,
    output alu_in_a, alu_in_b, alu_irq_clr,
    input  alu_out, alu_irq
  );

  modport slave (
    input  alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b,
    input  alu_in_a, alu_in_b, alu_irq_clr,
    output alu_out, alu_irq
  );

endinterface

// File: rtl/alu_irq_ctrl.sv
// Sticky irq flag; a set at the same edge as a clear wins.
// Build option ALU_ILLEGAL_IRQ_EN: illegal enable combinations also set the flag.
module alu_irq_ctrl (
  input  logic alu_clk,
  input  logic alu_rst_n,
  input  logic event_i,
  input  logic illegal_i,
  input  logic clr_i,
  output logic irq_o
);

`ifdef ALU_ILLEGAL_IRQ_EN
  localparam logic ILLEGAL_SETS = 1'b1;
`else
  localparam logic ILLEGAL_SETS = 1'b0;
`endif

  logic set_w;
  logic irq_q;
  logic irq_d;

  assign set_w = event_i | (illegal_i & ILLEGAL_SETS);

  always_comb begin
    irq_d = irq_q;
    if (set_w) begin
      irq_d = 1'b1;
    end else if (clr_i) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge alu_clk) begin
    if (!alu_rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/alu_dual_mode.sv
// Registered 8-bit ALU with a logic mode (A) and an arithmetic/shift mode (B).
// Build option ALU_ILLEGAL_IRQ_EN (see alu_irq_ctrl) makes both-modes-enabled raise irq.
module alu_dual_mode
  import alu_pkg::*;
(
  input  logic alu_clk,
  input  logic alu_rst_n,
  alu_if.slave bus
);

  logic              sel_a_w;
  logic              sel_b_w;
  logic              illegal_w;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W:0]   diff_w;
  logic [DATA_W-1:0] res_a_w;
  logic [DATA_W-1:0] res_b_w;
  logic              evt_b_w;
  logic              event_w;
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] out_d;

  assign sel_a_w   = bus.alu_enable &  bus.alu_enable_a & ~bus.alu_enable_b;
  assign sel_b_w   = bus.alu_enable & ~bus.alu_enable_a &  bus.alu_enable_b;
  assign illegal_w = bus.alu_enable &  bus.alu_enable_a &  bus.alu_enable_b;

  // Ninth bit carries the add carry-out and, for subtract, the borrow (a < b).
  assign sum_w  = {1'b0, bus.alu_in_a} + {1'b0, bus.alu_in_b};
  assign diff_w = {1'b0, bus.alu_in_a} - {1'b0, bus.alu_in_b};

  always_comb begin
    res_a_w = '0;
    case (op_a_e'(bus.alu_op_a))
      OPA_AND:  res_a_w = bus.alu_in_a & bus.alu_in_b;
      OPA_NAND: res_a_w = ~(bus.alu_in_a & bus.alu_in_b);
      OPA_OR:   res_a_w = bus.alu_in_a | bus.alu_in_b;
      OPA_XOR:  res_a_w = bus.alu_in_a ^ bus.alu_in_b;
      default:  res_a_w = '0;
    endcase
  end

  always_comb begin
    res_b_w = '0;
    evt_b_w = 1'b0;
    case (op_b_e'(bus.alu_op_b))
      OPB_ADD: begin
        res_b_w = sum_w[DATA_W-1:0];
        evt_b_w = sum_w[DATA_W];
      end
      OPB_SUB: begin
        res_b_w = diff_w[DATA_W-1:0];
        evt_b_w = diff_w[DATA_W];
      end
      OPB_SHL: res_b_w = bus.alu_in_a << bus.alu_in_b[2:0];
      OPB_SHR: res_b_w = bus.alu_in_a >> bus.alu_in_b[2:0];
      default: res_b_w = '0;
    endcase
    if (res_b_w == '0) begin
      evt_b_w = 1'b1;
    end
  end

  always_comb begin
    out_d   = out_q;
    event_w = 1'b0;
    if (sel_a_w) begin
      out_d   = res_a_w;
      event_w = (res_a_w == IRQ_A_VAL);
    end else if (sel_b_w) begin
      out_d   = res_b_w;
      event_w = evt_b_w;
    end
  end

  always_ff @(posedge alu_clk) begin
    if (!alu_rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  alu_irq_ctrl u_irq_ctrl (
    .alu_clk   (alu_clk),
    .alu_rst_n (alu_rst_n),
    .event_i   (event_w),
    .illegal_i (illegal_w),
    .clr_i     (bus.alu_irq_clr),
    .irq_o     (bus.alu_irq)
  );

  assign bus.alu_out = out_q;

endmodule

// File: tb/tb_alu_dual_mode.sv
// Scoreboard bench for alu_dual_mode: directed plan followed by random operations.
module tb_alu_dual_mode;
  import alu_pkg::*;

  logic alu_clk;
  logic alu_rst_n;

  alu_if bus ();

  alu_dual_mode dut (
    .alu_clk   (alu_clk),
    .alu_rst_n (alu_rst_n),
    .bus       (bus)
  );

  initial begin
    alu_clk = 1'b0;
    forever #5 alu_clk = ~alu_clk;
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_out_q[$];
  logic       exp_irq_q[$];
  int         tag_q[$];

  // Reference state, as the outputs should read after the edge just issued
  int unsigned m_out = 0;
  bit          m_irq = 1'b0;
  int          step_no = 0;

  task automatic cyc(input bit rst_n, input bit en, input bit ea, input bit eb,
                     input int unsigned opa, input int unsigned opb,
                     input int unsigned a, input int unsigned b, input bit clr);
    int unsigned r;
    int unsigned sum;
    bit          evt;
    alu_rst_n        = rst_n;
    bus.alu_enable   = en;
    bus.alu_enable_a = ea;
    bus.alu_enable_b = eb;
    bus.alu_op_a     = 2'(opa);
    bus.alu_op_b     = 2'(opb);
    bus.alu_in_a     = 8'(a);
    bus.alu_in_b     = 8'(b);
    bus.alu_irq_clr  = clr;

    evt = 1'b0;
    r   = m_out;
    if (en && ea && !eb) begin
      case (opa)
        0: r = a & b;
        1: r = (~(a & b)) & 255;
        2: r = a | b;
        default: r = a ^ b;
      endcase
      evt = (r == 255);
    end else if (en && eb && !ea) begin
      case (opb)
        0: begin sum = a + b; r = sum % 256; evt = (sum > 255); end
        1: begin r = (a + 256 - b) % 256; evt = (a < b); end
        2: r = (a * (1 << (b % 8))) % 256;
        default: r = a / (1 << (b % 8));
      endcase
      if (r == 0) evt = 1'b1;
    end
`ifdef ALU_ILLEGAL_IRQ_EN
    if (en && ea && eb) evt = 1'b1;
`endif
    if (!rst_n) begin
      m_out = 0;
      m_irq = 1'b0;
    end else begin
      m_out = r;
      if (evt) m_irq = 1'b1;
      else if (clr) m_irq = 1'b0;
    end
    exp_out_q.push_back(8'(m_out));
    exp_irq_q.push_back(m_irq);
    tag_q.push_back(step_no);
    step_no++;
    @(posedge alu_clk);
    #1;
  endtask

  // Monitor: one registered response per clock, sampled mid-cycle
  always @(negedge alu_clk) begin
    if (exp_out_q.size() > 0) begin
      logic [7:0] eo;
      logic       ei;
      int         t;
      eo = exp_out_q.pop_front();
      ei = exp_irq_q.pop_front();
      t  = tag_q.pop_front();
      checks++;
      if (bus.alu_out !== eo) begin
        errors++;
        $display("FAIL alu_out step %0d: got %h expected %h", t, bus.alu_out, eo);
      end
      checks++;
      if (bus.alu_irq !== ei) begin
        errors++;
        $display("FAIL alu_irq step %0d: got %b expected %b", t, bus.alu_irq, ei);
      end
    end
  end

  initial begin
    alu_rst_n = 1'b0;
    bus.alu_enable = 1'b0; bus.alu_enable_a = 1'b0; bus.alu_enable_b = 1'b0;
    bus.alu_op_a = '0; bus.alu_op_b = '0; bus.alu_in_a = '0; bus.alu_in_b = '0;
    bus.alu_irq_clr = 1'b0;

    // Reset held for two edges while a valid op is driven
    cyc(0, 1, 1, 0, 3, 0, 8'h0F, 8'hF0, 0);
    cyc(0, 1, 1, 0, 3, 0, 8'h0F, 8'hF0, 0);
    cyc(1, 1, 1, 0, 3, 0, 8'h0F, 8'hF0, 0);
    // Mode A sweep, clearing the irq left by the XOR
    for (int op = 0; op < 4; op++) cyc(1, 1, 1, 0, op, 3, 8'hCC, 8'hAA, 1);
    // Mode B arithmetic, each from a cleared irq
    cyc(1, 1, 0, 1, 1, 0, 8'h80, 8'h80, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 1, 2, 0, 8'h12, 8'h34, 1);
    cyc(1, 1, 0, 1, 0, 1, 8'h05, 8'h07, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 1, 0, 2, 8'h81, 8'h01, 1);
    cyc(1, 1, 0, 1, 0, 3, 8'h81, 8'h03, 1);
    // Clear race: event wins, then plain clear
    cyc(1, 1, 0, 1, 0, 0, 8'h80, 8'h80, 0);
    cyc(1, 1, 0, 1, 0, 0, 8'hFF, 8'h01, 1);
    cyc(1, 1, 1, 0, 0, 0, 8'h0F, 8'h0F, 1);
    // Hold with changing operands, then illegal combination
    cyc(1, 0, 1, 0, 3, 0, 8'h3C, 8'h55, 0);
    cyc(1, 1, 0, 0, 3, 0, 8'hA5, 8'h5A, 0);
    cyc(1, 1, 1, 1, 3, 0, 8'h0F, 8'hF0, 0);
    cyc(1, 1, 1, 1, 1, 0, 8'h00, 8'h00, 1);
    // Mid-operation reset after out=0x46 with irq set
    cyc(1, 1, 0, 1, 0, 0, 8'h80, 8'h80, 0);
    cyc(1, 1, 0, 1, 0, 0, 8'h12, 8'h34, 0);
    cyc(0, 1, 0, 1, 0, 0, 8'h80, 8'h80, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 19) != 0), ($urandom_range(0, 7) != 0),
          1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 255), $urandom_range(0, 255), ($urandom_range(0, 3) == 0));
    end

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int w = 0; w < 5 && exp_out_q.size() > 0; w++) @(negedge alu_clk);
    #1;
    checks++;
    if (exp_out_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_out_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
